// File: rtl/nsctrl_select_if.sv
// Bundles the source-side signals and the front-end-side outputs of the
// break-before-make control bus selector.
interface nsctrl_select_if #(
    parameter int NCH  = 8,
    parameter int NSRC = 2,
    parameter int SELW = 1
);
    logic [NSRC*NCH-1:0] src_bus;
    logic [SELW-1:0]     sel_req;
    logic                force_safe;
    logic [NCH-1:0]      ctrl_out;
    logic [SELW-1:0]     sel_cur;
    logic                switching;
    logic                switch_done;
    logic                sel_err;
    logic [7:0]          sw_count;

    // Sequencer side: drives the source buses and the selection request.
    modport master (
        output src_bus, sel_req, force_safe,
        input  ctrl_out, sel_cur, switching, switch_done, sel_err, sw_count
    );

    // Selector side.
    modport slave (
        input  src_bus, sel_req, force_safe,
        output ctrl_out, sel_cur, switching, switch_done, sel_err, sw_count
    );
endinterface

// File: rtl/nsctrl_select.sv
// Break-before-make selector for NMR pulse-sequence control buses. A change
// of source drives SAFE_VAL for DEAD_CYC cycles before the new source is
// routed, so two sequences are never spliced mid-pulse.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_RUN  | sel_cur routed to ctrl_out (or SAFE_VAL under force_safe)
// ST_DEAD | SAFE_VAL driven while the dead counter runs down to zero
module nsctrl_select #(
    parameter int             NCH      = 8,
    parameter int             NSRC     = 2,
    parameter int             SELW     = 1,
    parameter logic [NCH-1:0] SAFE_VAL = 8'h0C,
    parameter int             DEAD_CYC = 4
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    nsctrl_select_if.slave     bus
);
    typedef enum logic {ST_RUN, ST_DEAD} state_t;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_cnt, w_cnt_nxt;
    logic [SELW-1:0] r_target, w_target_nxt;
    logic [SELW-1:0] r_sel_cur, w_sel_cur_nxt;
    logic [NCH-1:0]  r_ctrl, w_ctrl_nxt;
    logic            r_done, w_done_nxt;
    logic            r_err, w_err_nxt;
    logic [7:0]      r_sw_count, w_sw_count_nxt;

    logic [NCH-1:0]  w_src_cur;
    logic [NCH-1:0]  w_src_tgt;
    logic            w_req_ok;

    assign w_req_ok = (32'(bus.sel_req) < NSRC);

    // Source muxes for the currently routed source and the pending target;
    // an explicit match loop keeps the selects inside the bus.
    always_comb begin
        w_src_cur = SAFE_VAL;
        w_src_tgt = SAFE_VAL;
        for (int k = 0; k < NSRC; k++) begin
            if (r_sel_cur == SELW'(k)) w_src_cur = bus.src_bus[k*NCH +: NCH];
            if (r_target  == SELW'(k)) w_src_tgt = bus.src_bus[k*NCH +: NCH];
        end
    end

    // Next-state and next-output decode for RUN/DEAD.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_target_nxt   = r_target;
        w_sel_cur_nxt  = r_sel_cur;
        w_ctrl_nxt     = r_ctrl;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_sw_count_nxt = r_sw_count;
        case (r_state)
            ST_RUN: begin
                if (w_req_ok && (bus.sel_req != r_sel_cur)) begin
                    w_target_nxt = bus.sel_req;
                    w_ctrl_nxt   = SAFE_VAL;
                    w_cnt_nxt    = 8'(DEAD_CYC - 1);
                    w_state_nxt  = ST_DEAD;
                end else begin
                    // Out-of-range requests keep routing the current source.
                    w_err_nxt  = ~w_req_ok;
                    w_ctrl_nxt = bus.force_safe ? SAFE_VAL : w_src_cur;
                end
            end
            ST_DEAD: begin
                if (r_cnt != 8'd0) begin
                    w_ctrl_nxt = SAFE_VAL;
                    w_cnt_nxt  = r_cnt - 8'd1;
                end else begin
                    w_sel_cur_nxt = r_target;
                    w_ctrl_nxt    = bus.force_safe ? SAFE_VAL : w_src_tgt;
                    w_done_nxt    = 1'b1;
                    if (r_sw_count != 8'hFF) w_sw_count_nxt = r_sw_count + 8'd1;
                    w_state_nxt   = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= 8'd0;
            r_target   <= '0;
            r_sel_cur  <= '0;
            r_ctrl     <= SAFE_VAL;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_sw_count <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_target   <= w_target_nxt;
            r_sel_cur  <= w_sel_cur_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_sw_count <= w_sw_count_nxt;
        end
    end

    assign bus.ctrl_out    = r_ctrl;
    assign bus.sel_cur     = r_sel_cur;
    assign bus.switching   = (r_state == ST_DEAD);
    assign bus.switch_done = r_done;
    assign bus.sel_err     = r_err;
    assign bus.sw_count    = r_sw_count;
endmodule
